// File: rtl/freq_meas_scheduler.sv
// Round-robin scheduler for a shared frequency-counter core: select, settle, clear, gate,
// wait for the count and store it per channel with valid/timeout flags.
module freq_meas_scheduler #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned GATE_W  = 24,
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 1024,
  localparam int unsigned SEL_W  = $clog2(N_CH)
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              enable,
  input  logic [N_CH-1:0]   chan_mask,
  input  logic [GATE_W-1:0] gate_len,
  output logic [SEL_W-1:0]  cnt_sel,
  output logic              cnt_clear,
  output logic              cnt_gate,
  input  logic              cnt_done,
  input  logic [CNT_W-1:0]  cnt_value,
  input  logic [SEL_W-1:0]  rd_idx,
  output logic [CNT_W-1:0]  rd_data,
  output logic [N_CH-1:0]   res_valid,
  output logic [N_CH-1:0]   res_tmo,
  input  logic [N_CH-1:0]   res_ack,
  output logic              busy,
  output logic              sweep_done
);

  localparam int unsigned StW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [StW-1:0]  SettleLast = StW'(SETTLE - 1);
  localparam logic [TmoW-1:0] TmoLast    = TmoW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StSelect, StClear, StGate, StWaitDone, StStore
  } state_e;

  state_e            state_q;
  logic [SEL_W-1:0]  ch_q, ptr_q;
  logic [StW-1:0]    settle_q;
  logic [GATE_W-1:0] gate_q;
  logic [TmoW-1:0]   tmo_q;
  logic              tmo_flag_q;
  logic [CNT_W-1:0]  cap_q;
  logic [CNT_W-1:0]  result_q [N_CH];
  logic [N_CH-1:0]   valid_q, tmo_bits_q;
  logic              clear_q, gate_out_q, busy_q, sweep_q;

  logic [SEL_W-1:0]  ch_inc, start_ch, pick_ch, top_ch;
  logic [SEL_W:0]    sum;
  logic              found;
  logic              mask_any;

  assign mask_any = |chan_mask;
  assign ch_inc   = (ch_q == SEL_W'(N_CH - 1)) ? '0 : ch_q + SEL_W'(1);

  // Lowest enabled channel at or after start_ch, wrapping modulo N_CH.
  always_comb begin
    start_ch = (state_q == StStore) ? ch_inc : ptr_q;
    pick_ch  = '0;
    found    = 1'b0;
    sum      = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      sum = {1'b0, start_ch} + (SEL_W + 1)'(i);
      if (sum >= (SEL_W + 1)'(N_CH)) sum = sum - (SEL_W + 1)'(N_CH);
      if (!found && chan_mask[sum[SEL_W-1:0]]) begin
        pick_ch = sum[SEL_W-1:0];
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    top_ch = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (chan_mask[SEL_W'(i)]) top_ch = SEL_W'(i);
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q    <= StIdle;
      ch_q       <= '0;
      ptr_q      <= '0;
      settle_q   <= '0;
      gate_q     <= '0;
      tmo_q      <= '0;
      tmo_flag_q <= 1'b0;
      cap_q      <= '0;
      result_q   <= '{default: '0};
      valid_q    <= '0;
      tmo_bits_q <= '0;
      clear_q    <= 1'b0;
      gate_out_q <= 1'b0;
      busy_q     <= 1'b0;
      sweep_q    <= 1'b0;
    end else begin
      clear_q <= 1'b0;
      sweep_q <= 1'b0;
      // A STORE to the same bit below overrides this acknowledge.
      valid_q <= valid_q & ~res_ack;
      if (!enable && state_q inside {StSelect, StClear, StGate, StWaitDone}) begin
        state_q    <= StIdle;
        busy_q     <= 1'b0;
        gate_out_q <= 1'b0;
        ptr_q      <= ch_q;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (enable && mask_any) begin
              ch_q     <= pick_ch;
              settle_q <= '0;
              busy_q   <= 1'b1;
              state_q  <= StSelect;
            end
          end
          StSelect: begin
            if (settle_q == SettleLast) begin
              clear_q <= 1'b1;
              gate_q  <= (gate_len == '0) ? GATE_W'(1) : gate_len;
              state_q <= StClear;
            end else begin
              settle_q <= settle_q + StW'(1);
            end
          end
          StClear: begin
            gate_out_q <= 1'b1;
            state_q    <= StGate;
          end
          StGate: begin
            if (gate_q == GATE_W'(1)) begin
              gate_out_q <= 1'b0;
              tmo_q      <= '0;
              state_q    <= StWaitDone;
            end else begin
              gate_q <= gate_q - GATE_W'(1);
            end
          end
          StWaitDone: begin
            if (cnt_done) begin
              cap_q      <= cnt_value;
              tmo_flag_q <= 1'b0;
              state_q    <= StStore;
            end else if (tmo_q == TmoLast) begin
              tmo_flag_q <= 1'b1;
              state_q    <= StStore;
            end else begin
              tmo_q <= tmo_q + TmoW'(1);
            end
          end
          StStore: begin
            if (!tmo_flag_q) begin
              result_q[ch_q]   <= cap_q;
              valid_q[ch_q]    <= 1'b1;
              tmo_bits_q[ch_q] <= 1'b0;
            end else begin
              tmo_bits_q[ch_q] <= 1'b1;
            end
            sweep_q <= mask_any && (ch_q == top_ch);
            ptr_q   <= ch_inc;
            if (enable && mask_any) begin
              ch_q     <= pick_ch;
              settle_q <= '0;
              state_q  <= StSelect;
            end else begin
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end
          end
          default: begin
            state_q    <= StIdle;
            busy_q     <= 1'b0;
            gate_out_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cnt_sel    = ch_q;
  assign cnt_clear  = clear_q;
  assign cnt_gate   = gate_out_q;
  assign res_valid  = valid_q;
  assign res_tmo    = tmo_bits_q;
  assign busy       = busy_q;
  assign sweep_done = sweep_q;
  assign rd_data    = result_q[rd_idx];

endmodule

// File: doc/freq_meas_scheduler.md
Name: freq_meas_scheduler

Overview:
- Sequences a shared frequency-counter core across N_CH clock-input channels by selecting a channel, clearing the counter, gating it for a programmed window and capturing the result.
- Scans the enabled channels round-robin.
- Holds one result register and a valid/timeout flag per channel.
- Sits between the AXI4-Lite register slave (config and readback) and the counter datapath.

Parameters:
- N_CH, 4, number of measured channels (2..16).
- CNT_W, 32, counter/result width.
- GATE_W, 24, gate-length field width in ACLK cycles.
- SETTLE, 4, ACLK cycles to wait after a mux change before clearing (>=1).
- TIMEOUT, 1024, max ACLK cycles to wait for cnt_done after the gate closes.

Ports:
- ACLK  in  1  system clock.
- ARESET  in  1  asynchronous reset, active-high.
- enable  in  1  run scanning while high.
- chan_mask  in  N_CH  per-channel enable; sampled when a channel is selected.
- gate_len  in  GATE_W  gate window in ACLK cycles; sampled on entry to CLEAR.
- cnt_sel  out  clog2(N_CH)  channel mux select to the counter.
- cnt_clear  out  1  one-cycle counter clear pulse.
- cnt_gate  out  1  counting window.
- cnt_done  in  1  pulse from the counter when cnt_value is stable after the gate falls.
- cnt_value  in  CNT_W  captured count.
- rd_idx  in  clog2(N_CH)  readback channel index.
- rd_data  out  CNT_W  result[rd_idx], combinational.
- res_valid  out  N_CH  result holds a fresh measurement.
- res_tmo  out  N_CH  last attempt on that channel timed out.
- res_ack  in  N_CH  write-1-to-clear of res_valid bits.
- busy  out  1  state != IDLE.
- sweep_done  out  1  one-cycle pulse after storing the highest-indexed enabled channel.

Behaviour:
- Reset (async, any state):
  - Force IDLE.
  - All results = 0; res_valid, res_tmo, cnt_clear, cnt_gate, busy, sweep_done = 0; cnt_sel = 0.
  - Next-channel pointer = 0.
- FSM states: IDLE, SELECT, CLEAR, GATE, WAIT_DONE, STORE.
- IDLE:
  - If enable=1 and chan_mask!=0, pick the lowest enabled index >= pointer (wrapping).
  - Drive cnt_sel and go to SELECT next cycle.
  - If mask==0, stay in IDLE.
- SELECT: hold for exactly SETTLE cycles, then go to CLEAR.
- CLEAR:
  - cnt_clear=1 for one cycle.
  - Latch gate_len; a value of 0 is treated as 1.
- GATE: cnt_gate=1 for exactly the latched gate_len cycles, then go to WAIT_DONE.
- WAIT_DONE:
  - Timeout counter starts at 0.
  - cnt_done=1 goes to STORE.
  - Counter reaching TIMEOUT goes to STORE with the timeout flag set.
  - cnt_done asserted in the same cycle as the timeout takes priority (success).
- STORE (1 cycle):
  - Success: result[ch]=cnt_value, res_valid[ch]=1, res_tmo[ch]=0.
  - Timeout: result unchanged, res_tmo[ch]=1, res_valid[ch] unchanged.
  - sweep_done=1 if ch is the highest set bit of chan_mask.
  - Pointer = ch+1 mod N_CH.
  - Next: SELECT of the next enabled channel if enable=1 and mask!=0, else IDLE.
- cnt_done outside WAIT_DONE is ignored.
- res_ack[i]=1 clears res_valid[i] next cycle. A STORE setting the same bit in the same cycle wins (bit stays 1).
- enable falling in SELECT, CLEAR, GATE or WAIT_DONE:
  - Abort: next cycle IDLE, cnt_gate=0, nothing stored.
  - Pointer stays at the aborted channel.
- chan_mask changing mid-measurement does not abort; it takes effect at the next selection.
- Latency of one measurement from SELECT entry to STORE = SETTLE + 1 + gate_len + (cycles to cnt_done) + 1.
- busy=1 in every state except IDLE.
- All outputs registered except rd_data.

Test Plan:
- Reset-release sweep:
  - Stimulus: reset released; N_CH=4, mask=4'b1111, gate_len=100, SETTLE=4; counter model returns 1000+ch three cycles after the gate falls.
  - Required: cnt_gate high exactly 100 cycles per channel.
  - Required: results 1000..1003; res_valid=4'b1111; one sweep_done per sweep, in the channel-3 STORE.
  - Required: period per channel = 4+1+100+3+1 = 109 cycles.
- Sparse mask:
  - Stimulus: mask=4'b0101.
  - Required: cnt_sel sequence 0,2,0,2; sweep_done after channel 2 only; channels 1 and 3 untouched.
- Timeout:
  - Stimulus: cnt_done never asserted for channel 1, TIMEOUT=1024.
  - Required: res_tmo[1]=1 after 1024 WAIT_DONE cycles; result[1] keeps its previous value.
  - Required: the next successful channel-1 measurement clears res_tmo[1].
- Abort:
  - Stimulus: enable dropped in cycle 50 of GATE on channel 2.
  - Required: cnt_gate=0 and IDLE next cycle; res_valid[2] unchanged.
  - Required: re-enable restarts at channel 2.
- gate_len=0:
  - Required: behaves as gate_len=1 (cnt_gate high exactly one cycle).
- Ack/store collision:
  - Stimulus: res_ack[0]=1 in the channel-0 STORE cycle.
  - Required: res_valid[0] stays 1.
  - Stimulus: asynchronous ARESET asserted mid-GATE.
  - Required: all outputs 0 immediately.
